// File: rtl/dmem_arbiter_if.sv
// Request/response bundle for the two data-memory masters plus the shared memory port.
// slave = arbiter side, master = requesters and the memory that answers them.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 12
);
    logic [1:0]             req_i;
    logic [1:0]             we_i;
    logic [1:0][1:0]        size_i;
    logic [1:0]             uns_i;
    logic [1:0][ADDR_W-1:0] addr_i;
    logic [1:0][31:0]       wdata_i;
    logic [1:0]             gnt_o;
    logic [1:0]             done_o;
    logic [31:0]            rdata_o;
    logic                   err_o;
    logic [ADDR_W-1:0]      mem_addr_o;
    logic                   mem_en_o;
    logic                   mem_we_o;
    logic [3:0]             mem_be_o;
    logic [31:0]            mem_wdata_o;
    logic [31:0]            mem_rdata_i;

    modport slave (
        input  req_i, we_i, size_i, uns_i, addr_i, wdata_i, mem_rdata_i,
        output gnt_o, done_o, rdata_o, err_o,
               mem_addr_o, mem_en_o, mem_we_o, mem_be_o, mem_wdata_o
    );

    modport master (
        output req_i, we_i, size_i, uns_i, addr_i, wdata_i, mem_rdata_i,
        input  gnt_o, done_o, rdata_o, err_o,
               mem_addr_o, mem_en_o, mem_we_o, mem_be_o, mem_wdata_o
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter and byte/half/word access sequencer for the data memory.
// One access takes IDLE -> ACCESS (grant + memory strobe) -> RESP (done + extended read data).
module dmem_arbiter #(
    parameter int ADDR_W = 12
) (
    input  logic           clk,
    input  logic           rst_n,
    dmem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state_q;
    logic        last_q;
    logic        port_q;
    logic        we_q;
    logic        uns_q;
    logic        bad_q;
    logic [1:0]  size_q;
    logic [1:0]  off_q;
    logic [1:0]  gnt_q;
    logic [1:0]  done_q;
    logic        err_q;
    logic        mem_en_q;
    logic        mem_we_q;
    logic [3:0]  mem_be_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0] mem_wdata_q;

    logic              win;
    logic [1:0]        sel_size;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_wdata;
    logic [1:0]        sel_off;
    logic              sel_bad;
    logic [3:0]        sel_be;
    logic [31:0]       sel_lanes;
    logic [31:0]       rd_shift;
    logic [31:0]       rd_ext;

    // On contention the port that was not granted last time wins.
    always_comb begin
        if (&bus.req_i) win = ~last_q;
        else            win = bus.req_i[1];
    end

    assign sel_size  = bus.size_i[win];
    assign sel_addr  = bus.addr_i[win];
    assign sel_wdata = bus.wdata_i[win];
    assign sel_off   = sel_addr[1:0];
    assign sel_bad   = (sel_size == 2'b11)
                     | ((sel_size == 2'b01) & sel_off[0])
                     | ((sel_size == 2'b10) & (sel_off != 2'b00));

    always_comb begin
        sel_be    = '0;
        sel_lanes = '0;
        case (sel_size)
            2'b00: begin
                sel_be    = 4'b0001 << sel_off;
                sel_lanes = {4{sel_wdata[7:0]}};
            end
            2'b01: begin
                sel_be    = 4'b0011 << sel_off;
                sel_lanes = {2{sel_wdata[15:0]}};
            end
            2'b10: begin
                sel_be    = 4'b1111;
                sel_lanes = sel_wdata;
            end
            default: ;
        endcase
    end

    always_comb begin
        rd_shift = bus.mem_rdata_i >> {off_q, 3'b000};
        case (size_q)
            2'b00:   rd_ext = {{24{rd_shift[7]  & ~uns_q}}, rd_shift[7:0]};
            2'b01:   rd_ext = {{16{rd_shift[15] & ~uns_q}}, rd_shift[15:0]};
            default: rd_ext = rd_shift;
        endcase
    end

    // Strobes and lane data are registered at the grant edge so they appear only during ACCESS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            port_q      <= 1'b0;
            we_q        <= 1'b0;
            uns_q       <= 1'b0;
            bad_q       <= 1'b0;
            size_q      <= '0;
            off_q       <= '0;
            gnt_q       <= '0;
            done_q      <= '0;
            err_q       <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            gnt_q       <= '0;
            done_q      <= '0;
            err_q       <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            case (state_q)
                IDLE: begin
                    if (|bus.req_i) begin
                        last_q      <= win;
                        port_q      <= win;
                        we_q        <= bus.we_i[win];
                        uns_q       <= bus.uns_i[win];
                        size_q      <= sel_size;
                        off_q       <= sel_off;
                        bad_q       <= sel_bad;
                        gnt_q       <= win ? 2'b10 : 2'b01;
                        mem_en_q    <= ~sel_bad;
                        mem_we_q    <= ~sel_bad & bus.we_i[win];
                        mem_be_q    <= sel_bad ? 4'b0000 : sel_be;
                        mem_addr_q  <= {sel_addr[ADDR_W-1:2], 2'b00};
                        mem_wdata_q <= sel_lanes;
                        state_q     <= ACCESS;
                    end
                end
                ACCESS: begin
                    done_q  <= {port_q, ~port_q};
                    err_q   <= bad_q;
                    state_q <= RESP;
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.gnt_o       = gnt_q;
    assign bus.done_o      = done_q;
    assign bus.err_o       = err_q;
    assign bus.rdata_o     = ((state_q == RESP) && !we_q && !err_q) ? rd_ext : '0;
    assign bus.mem_en_o    = mem_en_q;
    assign bus.mem_we_o    = mem_we_q;
    assign bus.mem_be_o    = mem_be_q;
    assign bus.mem_addr_o  = mem_addr_q;
    assign bus.mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random single-port traffic checked
// against a byte-array reference of memory contents and the access rules.
module tb_dmem_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(12)) bus ();
    dmem_arbiter #(.ADDR_W(12)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    // Word memory with one-cycle read latency.
    logic [31:0] mem [1024] = '{default: 32'h0};
    always @(posedge clk) begin
        if (bus.mem_en_o) begin
            if (bus.mem_we_o)
                for (int i = 0; i < 4; i++)
                    if (bus.mem_be_o[i]) mem[bus.mem_addr_o[11:2]][8*i +: 8] <= bus.mem_wdata_o[8*i +: 8];
            bus.mem_rdata_i <= mem[bus.mem_addr_o[11:2]];
        end
    end

    int checks = 0;
    int failures = 0;

    logic [7:0] ref_mem [4096];
    int m_last;

    int          obs_glat, obs_dlat;
    logic [1:0]  obs_gnt, obs_done;
    logic        obs_en, obs_we, obs_err;
    logic [3:0]  obs_be;
    logic [11:0] obs_addr;
    logic [31:0] obs_wdata, obs_rdata;

    logic        e_err;
    logic [3:0]  e_be;
    logic [31:0] e_rd, e_lanes, e_mask;

    // Expected outcome from the access rules, and update of the byte-level memory reference.
    task automatic model_txn(input int p, input logic w, input logic [1:0] sz, input logic u,
                             input logic [11:0] a, input logic [31:0] d);
        int nb, off;
        logic [31:0] v;
        nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        off = int'(a) % 4;
        m_last = p;
        e_err = (sz == 2'd3) || (int'(a) % nb != 0);
        e_be = '0; e_rd = '0; e_lanes = '0; e_mask = '0;
        if (!e_err) begin
            for (int i = 0; i < nb; i++) begin
                e_be[off+i] = 1'b1;
                e_lanes[8*(off+i) +: 8] = d[8*i +: 8];
                e_mask[8*(off+i) +: 8] = 8'hFF;
            end
            if (w) begin
                for (int i = 0; i < nb; i++) ref_mem[int'(a)+i] = d[8*i +: 8];
            end else begin
                v = '0;
                for (int i = 0; i < nb; i++) v[8*i +: 8] = ref_mem[int'(a)+i];
                if (!u && nb < 4 && v[8*nb-1])
                    for (int b = 8*nb; b < 32; b++) v[b] = 1'b1;
                e_rd = v;
            end
        end
    endtask

    // Drives one request from an IDLE cycle, drops it after the grant, records observations.
    task automatic run_txn(input int p, input logic w, input logic [1:0] sz, input logic u,
                           input logic [11:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.we_i[p] = w;
        bus.size_i[p] = sz;
        bus.uns_i[p] = u;
        bus.addr_i[p] = a;
        bus.wdata_i[p] = d;
        bus.req_i[p] = 1'b1;
        obs_glat = 99;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (bus.gnt_o[p]) begin obs_glat = n; break; end
        end
        obs_gnt = bus.gnt_o;
        obs_en = bus.mem_en_o;
        obs_we = bus.mem_we_o;
        obs_be = bus.mem_be_o;
        obs_addr = bus.mem_addr_o;
        obs_wdata = bus.mem_wdata_o;
        bus.req_i[p] = 1'b0;
        obs_dlat = 99;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (bus.done_o[p]) begin obs_dlat = n; break; end
        end
        obs_done = bus.done_o;
        obs_rdata = bus.rdata_o;
        obs_err = bus.err_o;
    endtask

    task automatic test_reset;
        logic [127:0] outs;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        outs = {bus.gnt_o, bus.done_o, bus.rdata_o, bus.err_o, bus.mem_en_o, bus.mem_we_o,
                bus.mem_be_o, bus.mem_addr_o, bus.mem_wdata_o};
        checks++;
        if (outs !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h want=0", outs);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_word_rw;
        model_txn(0, 1'b1, 2'd2, 1'b0, 12'h010, 32'hDEADBEEF);
        run_txn(0, 1'b1, 2'd2, 1'b0, 12'h010, 32'hDEADBEEF);
        checks++;
        if (obs_glat !== 1) begin failures++; $display("FAIL wr_gnt_latency got=%0d want=1", obs_glat); end
        checks++;
        if ({obs_en, obs_we, obs_be} !== 6'b11_1111) begin
            failures++; $display("FAIL wr_strobe en_we_be got=%b want=111111", {obs_en, obs_we, obs_be});
        end
        checks++;
        if (obs_addr !== 12'h010 || obs_wdata !== 32'hDEADBEEF) begin
            failures++; $display("FAIL wr_addr_data got=%h/%h want=010/deadbeef", obs_addr, obs_wdata);
        end
        model_txn(0, 1'b0, 2'd2, 1'b0, 12'h010, 32'h0);
        run_txn(0, 1'b0, 2'd2, 1'b0, 12'h010, 32'h0);
        checks++;
        if (obs_dlat !== 1 || obs_done !== 2'b01) begin
            failures++; $display("FAIL rd_done got lat=%0d done=%b want lat=1 done=01", obs_dlat, obs_done);
        end
        checks++;
        if (obs_rdata !== 32'hDEADBEEF || obs_err !== 1'b0) begin
            failures++; $display("FAIL rd_word got=%h err=%b want=deadbeef err=0", obs_rdata, obs_err);
        end
    endtask

    task automatic test_subword;
        model_txn(0, 1'b0, 2'd0, 1'b0, 12'h013, 32'h0);
        run_txn(0, 1'b0, 2'd0, 1'b0, 12'h013, 32'h0);
        checks++;
        if (obs_rdata !== 32'hFFFFFFDE) begin failures++; $display("FAIL rd_sbyte got=%h want=ffffffde", obs_rdata); end
        model_txn(0, 1'b0, 2'd0, 1'b1, 12'h013, 32'h0);
        run_txn(0, 1'b0, 2'd0, 1'b1, 12'h013, 32'h0);
        checks++;
        if (obs_rdata !== 32'h000000DE) begin failures++; $display("FAIL rd_ubyte got=%h want=000000de", obs_rdata); end
        model_txn(0, 1'b0, 2'd1, 1'b0, 12'h012, 32'h0);
        run_txn(0, 1'b0, 2'd1, 1'b0, 12'h012, 32'h0);
        checks++;
        if (obs_rdata !== 32'hFFFFDEAD) begin failures++; $display("FAIL rd_shalf got=%h want=ffffdead", obs_rdata); end
        model_txn(0, 1'b1, 2'd0, 1'b0, 12'h011, 32'h0000005A);
        run_txn(0, 1'b1, 2'd0, 1'b0, 12'h011, 32'h0000005A);
        checks++;
        if (obs_be !== 4'b0010 || obs_wdata[15:8] !== 8'h5A) begin
            failures++; $display("FAIL wr_byte got be=%b wdata=%h want be=0010 lane1=5a", obs_be, obs_wdata);
        end
        model_txn(0, 1'b0, 2'd2, 1'b0, 12'h010, 32'h0);
        run_txn(0, 1'b0, 2'd2, 1'b0, 12'h010, 32'h0);
        checks++;
        if (obs_rdata !== 32'hDEAD5AEF) begin failures++; $display("FAIL rd_after_byte got=%h want=dead5aef", obs_rdata); end
    endtask

    task automatic test_errors;
        model_txn(0, 1'b0, 2'd1, 1'b0, 12'h021, 32'h0);
        run_txn(0, 1'b0, 2'd1, 1'b0, 12'h021, 32'h0);
        checks++;
        if (obs_err !== 1'b1 || obs_en !== 1'b0 || obs_done !== 2'b01 || obs_rdata !== 32'h0) begin
            failures++;
            $display("FAIL err_half got err=%b en=%b done=%b rd=%h want err=1 en=0 done=01 rd=0",
                     obs_err, obs_en, obs_done, obs_rdata);
        end
        model_txn(0, 1'b1, 2'd2, 1'b0, 12'h022, 32'h12345678);
        run_txn(0, 1'b1, 2'd2, 1'b0, 12'h022, 32'h12345678);
        checks++;
        if (obs_err !== 1'b1 || obs_en !== 1'b0 || obs_we !== 1'b0) begin
            failures++; $display("FAIL err_word got err=%b en=%b we=%b want 1/0/0", obs_err, obs_en, obs_we);
        end
        model_txn(0, 1'b0, 2'd2, 1'b0, 12'h020, 32'h0);
        run_txn(0, 1'b0, 2'd2, 1'b0, 12'h020, 32'h0);
        checks++;
        if (obs_rdata !== 32'h0) begin failures++; $display("FAIL err_no_side_effect got=%h want=0", obs_rdata); end
        model_txn(1, 1'b0, 2'd3, 1'b0, 12'h030, 32'h0);
        run_txn(1, 1'b0, 2'd3, 1'b0, 12'h030, 32'h0);
        checks++;
        if (obs_err !== 1'b1 || obs_done !== 2'b10) begin
            failures++; $display("FAIL err_size11 got err=%b done=%b want err=1 done=10", obs_err, obs_done);
        end
    endtask

    task automatic test_early_drop;
        model_txn(1, 1'b1, 2'd2, 1'b0, 12'h040, 32'hCAFEF00D);
        run_txn(1, 1'b1, 2'd2, 1'b0, 12'h040, 32'hCAFEF00D);
        checks++;
        if (obs_glat !== 1 || obs_dlat !== 1 || obs_done !== 2'b10) begin
            failures++;
            $display("FAIL drop_done got glat=%0d dlat=%0d done=%b want 1/1/10", obs_glat, obs_dlat, obs_done);
        end
        model_txn(1, 1'b0, 2'd2, 1'b0, 12'h040, 32'h0);
        run_txn(1, 1'b0, 2'd2, 1'b0, 12'h040, 32'h0);
        checks++;
        if (obs_rdata !== 32'hCAFEF00D) begin failures++; $display("FAIL drop_landed got=%h want=cafef00d", obs_rdata); end
    endtask

    task automatic test_contention;
        int gnts[$];
        int dn0[$];
        int dn1[$];
        int bad;
        int exp_port;
        @(negedge clk);
        for (int p = 0; p < 2; p++) begin
            bus.we_i[p] = 1'b0; bus.size_i[p] = 2'd2; bus.uns_i[p] = 1'b0;
            bus.addr_i[p] = 12'h010; bus.wdata_i[p] = '0;
        end
        bus.req_i = 2'b11;
        bad = 0;
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            if (bus.gnt_o == 2'b11 || bus.done_o == 2'b11 || (|bus.gnt_o && |bus.done_o)) bad++;
            if (bus.gnt_o == 2'b01) gnts.push_back(0);
            if (bus.gnt_o == 2'b10) gnts.push_back(1);
            if (bus.done_o[0]) dn0.push_back(c);
            if (bus.done_o[1]) dn1.push_back(c);
        end
        bus.req_i = 2'b00;
        checks++;
        if (bad !== 0) begin failures++; $display("FAIL cont_overlap got=%0d want=0", bad); end
        checks++;
        if (gnts.size() !== 8 || dn0.size() !== 4 || dn1.size() !== 4) begin
            failures++;
            $display("FAIL cont_counts got gnts=%0d d0=%0d d1=%0d want 8/4/4", gnts.size(), dn0.size(), dn1.size());
        end
        exp_port = (m_last == 1) ? 0 : 1;
        foreach (gnts[i]) begin
            checks++;
            if (gnts[i] !== exp_port) begin
                failures++; $display("FAIL cont_order idx=%0d got=%0d want=%0d", i, gnts[i], exp_port);
            end
            m_last = exp_port;
            exp_port = 1 - exp_port;
        end
        for (int i = 1; i < dn0.size(); i++) begin
            checks++;
            if (dn0[i] - dn0[i-1] !== 6) begin
                failures++; $display("FAIL cont_period0 got=%0d want=6", dn0[i] - dn0[i-1]);
            end
        end
        for (int i = 1; i < dn1.size(); i++) begin
            checks++;
            if (dn1[i] - dn1[i-1] !== 6) begin
                failures++; $display("FAIL cont_period1 got=%0d want=6", dn1[i] - dn1[i-1]);
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        logic [127:0] outs;
        int glat;
        int spurious;
        @(negedge clk);
        bus.we_i[1] = 1'b1; bus.size_i[1] = 2'd2; bus.uns_i[1] = 1'b0;
        bus.addr_i[1] = 12'h050; bus.wdata_i[1] = 32'h0BADBEEF;
        bus.req_i[1] = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.gnt_o !== 2'b10) begin failures++; $display("FAIL rstmid_gnt got=%b want=10", bus.gnt_o); end
        rst_n = 1'b0;
        bus.req_i = 2'b00;
        #1;
        outs = {bus.gnt_o, bus.done_o, bus.rdata_o, bus.err_o, bus.mem_en_o, bus.mem_we_o,
                bus.mem_be_o, bus.mem_addr_o, bus.mem_wdata_o};
        checks++;
        if (outs !== '0) begin failures++; $display("FAIL rstmid_outputs got=%h want=0", outs); end
        spurious = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.done_o !== 2'b00) spurious++;
        end
        rst_n = 1'b1;
        checks++;
        if (spurious !== 0) begin failures++; $display("FAIL rstmid_no_done got=%0d want=0", spurious); end
        for (int p = 0; p < 2; p++) begin
            bus.we_i[p] = 1'b0; bus.size_i[p] = 2'd2; bus.uns_i[p] = 1'b0; bus.addr_i[p] = 12'h050;
        end
        bus.req_i = 2'b11;
        glat = 99;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (|bus.gnt_o) begin glat = n; break; end
        end
        checks++;
        if (glat !== 1 || bus.gnt_o !== 2'b01) begin
            failures++; $display("FAIL rstmid_first_gnt got lat=%0d gnt=%b want lat=1 gnt=01", glat, bus.gnt_o);
        end
        bus.req_i = 2'b00;
        @(negedge clk);
        checks++;
        if (bus.done_o !== 2'b01 || bus.rdata_o !== 32'h0) begin
            failures++;
            $display("FAIL rstmid_discarded got done=%b rd=%h want done=01 rd=0", bus.done_o, bus.rdata_o);
        end
        m_last = 0;
    endtask

    task automatic test_random;
        int p;
        logic w, u;
        logic [1:0] sz;
        logic [11:0] a;
        logic [31:0] d;
        for (int k = 0; k < 40; k++) begin
            p = int'($urandom_range(0, 1));
            w = 1'($urandom_range(0, 1));
            u = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            a = 12'($urandom_range(0, 63));
            d = $urandom;
            model_txn(p, w, sz, u, a, d);
            run_txn(p, w, sz, u, a, d);
            checks++;
            if (obs_glat !== 1 || obs_dlat !== 1 || obs_done !== (p == 1 ? 2'b10 : 2'b01)) begin
                failures++;
                $display("FAIL rnd_timing k=%0d got glat=%0d dlat=%0d done=%b", k, obs_glat, obs_dlat, obs_done);
            end
            checks++;
            if (obs_err !== e_err || obs_rdata !== e_rd) begin
                failures++;
                $display("FAIL rnd_resp k=%0d a=%h sz=%0d got err=%b rd=%h want err=%b rd=%h",
                         k, a, sz, obs_err, obs_rdata, e_err, e_rd);
            end
            checks++;
            if (e_err) begin
                if (obs_en !== 1'b0 || obs_we !== 1'b0) begin
                    failures++; $display("FAIL rnd_err_strobe k=%0d got en=%b we=%b want 0/0", k, obs_en, obs_we);
                end
            end else if (obs_en !== 1'b1 || obs_we !== w || obs_be !== e_be || obs_addr !== (a & 12'hFFC)
                         || (w && ((obs_wdata & e_mask) !== e_lanes))) begin
                failures++;
                $display("FAIL rnd_port k=%0d got en=%b we=%b be=%b addr=%h wd=%h want we=%b be=%b addr=%h lanes=%h",
                         k, obs_en, obs_we, obs_be, obs_addr, obs_wdata, w, e_be, a & 12'hFFC, e_lanes);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        bus.req_i = '0;
        bus.we_i = '0;
        bus.size_i = '0;
        bus.uns_i = '0;
        bus.addr_i = '0;
        bus.wdata_i = '0;
        for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;
        m_last = 1;
        test_reset();
        test_word_rw();
        test_subword();
        test_errors();
        test_early_drop();
        test_contention();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
